// File: rtl/grid_pattern_pkg.sv
// Shared color constants and mode encoding for the play-field pattern generator.
package grid_pattern_pkg;

   localparam logic [5:0] COLOR_OFF    = 6'b000000;
   localparam logic [5:0] COLOR_HEADER = 6'b001100;
   localparam logic [5:0] COLOR_GRID   = 6'b010101;
   localparam logic [5:0] COLOR_LANE_A = 6'b000011;
   localparam logic [5:0] COLOR_LANE_B = 6'b111111;
   localparam logic [5:0] COLOR_BG     = 6'b000100;

   typedef enum logic [1:0] {
      MODE_GRID  = 2'd0,
      MODE_LANES = 2'd1,
      MODE_SOLID = 2'd2,
      MODE_BLANK = 2'd3
   } mode_t;

endpackage

// File: rtl/grid_pattern_gen_lane_scroller.sv
// One lane's horizontal scroll offset; steps by STEP per advance, up (DIR=0) or down (DIR=1).
module lane_scroller #(
   parameter int COL_BITS = 10,
   parameter int STEP     = 4,
   parameter bit DIR      = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                advance_i,
   output logic [COL_BITS:0]   off_o
);

   localparam logic [COL_BITS:0] STEP_W = (COL_BITS+1)'(STEP);

   logic [COL_BITS:0] off_q, off_d;

   // Natural modulo-2^(COL_BITS+1) wrap in both directions.
   always_comb begin
      off_d = off_q;
      if (advance_i) begin
         if (DIR) off_d = off_q - STEP_W;
         else     off_d = off_q + STEP_W;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) off_q <= '0;
      else        off_q <= off_d;
   end

   assign off_o = off_q;

endmodule

// File: rtl/grid_pattern_gen.sv
// Play-field pattern generator: grid, scrolling lanes, solid or blank fill with a header bar, 1-cycle registered output.
module grid_pattern_gen
   import grid_pattern_pkg::*;
#(
   parameter int COL_BITS    = 10,
   parameter int FIELD_LEFT  = 96,
   parameter int FIELD_RIGHT = 544,
   parameter int TILE_LOG2   = 5,
   parameter int HEADER_ROWS = 16,
   parameter int NUM_LANES   = 4,
   parameter int LANE_ROW0   = 64,
   parameter int SCROLL_STEP = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [COL_BITS-1:0] colPos,
   input  logic [COL_BITS-1:0] rowPos,
   input  logic                frame_start,
   input  logic [1:0]          mode,
   input  logic                pause,
   output logic                display_enable,
   output logic [5:0]          color
);

   localparam int TILE = 1 << TILE_LOG2;
   localparam logic [COL_BITS-1:0] FL  = COL_BITS'(FIELD_LEFT);
   localparam logic [COL_BITS-1:0] FR  = COL_BITS'(FIELD_RIGHT);
   localparam logic [COL_BITS-1:0] HDR = COL_BITS'(HEADER_ROWS);

   logic [NUM_LANES-1:0][COL_BITS:0] offs;
   logic                             advance;

   // Offsets run regardless of mode so lanes keep moving while hidden.
   assign advance = frame_start & ~pause;

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      lane_scroller #(
         .COL_BITS (COL_BITS),
         .STEP     (SCROLL_STEP * (k + 1)),
         .DIR      (1'(k % 2))
      ) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .advance_i (advance),
         .off_o     (offs[k])
      );
   end

   mode_t               md;
   logic                in_field, header, grid_lum, lane_hit;
   logic [COL_BITS-1:0] row_p1;
   logic [COL_BITS:0]   sel_off, stripe_sum;
   logic                display_enable_q, display_enable_d;
   logic [5:0]          color_q, color_d;

   assign md         = mode_t'(mode);
   assign in_field   = (colPos >= FL) && (colPos <= FR);
   assign header     = rowPos < HDR;
   assign row_p1     = rowPos + COL_BITS'(1);
   assign grid_lum   = (colPos[TILE_LOG2-1:0] == '0) || (row_p1[TILE_LOG2-1:0] == '0);
   assign stripe_sum = {1'b0, colPos} + sel_off;

   always_comb begin
      lane_hit = 1'b0;
      sel_off  = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (int'(rowPos) >= LANE_ROW0 + k * TILE && int'(rowPos) < LANE_ROW0 + (k + 1) * TILE) begin
            lane_hit = 1'b1;
            sel_off  = offs[k];
         end
      end
   end

   always_comb begin
      display_enable_d = 1'b0;
      color_d          = COLOR_OFF;
      if (in_field) begin
         display_enable_d = 1'b1;
         if (md == MODE_BLANK)  color_d = COLOR_OFF;
         else if (header)       color_d = COLOR_HEADER;
         else begin
            case (md)
               MODE_GRID:  color_d = grid_lum ? COLOR_GRID : COLOR_OFF;
               MODE_LANES: color_d = !lane_hit ? COLOR_BG :
                                     (stripe_sum[TILE_LOG2] ? COLOR_LANE_B : COLOR_LANE_A);
               MODE_SOLID: color_d = COLOR_BG;
               default:    color_d = COLOR_OFF;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         display_enable_q <= 1'b0;
         color_q          <= COLOR_OFF;
      end else begin
         display_enable_q <= display_enable_d;
         color_q          <= color_d;
      end
   end

   assign display_enable = display_enable_q;
   assign color          = color_q;

endmodule

// File: tb/tb_grid_pattern_gen.sv
// Bench for grid_pattern_gen: fixed vector table, multi-cycle scroll/pause/wrap/reset sequences, random run vs model.
module tb_grid_pattern_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] colPos, rowPos;
   logic       frame_start;
   logic [1:0] mode;
   logic       pause;
   logic       display_enable;
   logic [5:0] color;

   int chk = 0;
   int err = 0;
   int m_off[4];

   typedef struct {
      int col;
      int row;
      int md;
      int en;
      int color;
   } vec_t;

   vec_t vecs[16];

   grid_pattern_gen dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .colPos         (colPos),
      .rowPos         (rowPos),
      .frame_start    (frame_start),
      .mode           (mode),
      .pause          (pause),
      .display_enable (display_enable),
      .color          (color)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      chk++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference pixel from the written rules; returns en*64 + color.
   function automatic int ref_pix(int col, int row, int md);
      int k;
      if (col < 96 || col > 544) return 0;
      if (md == 3) return 64;
      if (row < 16) return 64 + 12;
      case (md)
         0: return (col % 32 == 0 || ((row + 1) % 1024) % 32 == 0) ? 64 + 21 : 64;
         1: begin
            if (row >= 64 && row < 64 + 4 * 32) begin
               k = (row - 64) / 32;
               return ((((col + m_off[k]) % 2048) / 32) % 2 == 1) ? 64 + 63 : 64 + 3;
            end
            return 64 + 4;
         end
         default: return 64 + 4;
      endcase
   endfunction

   function automatic void model_advance();
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) m_off[k] = (m_off[k] + 4 * (k + 1)) % 2048;
         else            m_off[k] = (m_off[k] - 4 * (k + 1) + 2048) % 2048;
      end
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 4; k++) m_off[k] = 0;
   endfunction

   // Drives one pixel, checks the registered result, then applies the frame update to the model.
   task automatic step(input int col, input int row, input int md, input bit fs, input bit ps);
      int exp;
      colPos      = 10'(col);
      rowPos      = 10'(row);
      mode        = 2'(md);
      frame_start = fs;
      pause       = ps;
      exp         = ref_pix(col, row, md);
      @(posedge clk);
      #1;
      check("pixel", int'({display_enable, color}), exp);
      if (fs && !ps) model_advance();
   endtask

   task automatic check_offs();
      for (int k = 0; k < 4; k++) check("offset", int'(dut.offs[k]), m_off[k]);
   endtask

   initial begin
      int exp_off[4];

      vecs[0]  = '{96, 31, 0, 1, 21};
      vecs[1]  = '{97, 40, 0, 1, 0};
      vecs[2]  = '{95, 31, 0, 0, 0};
      vecs[3]  = '{200, 10, 1, 1, 12};
      vecs[4]  = '{96, 64, 1, 1, 63};
      vecs[5]  = '{128, 64, 1, 1, 3};
      vecs[6]  = '{160, 96, 1, 1, 63};
      vecs[7]  = '{100, 200, 1, 1, 4};
      vecs[8]  = '{300, 20, 2, 1, 4};
      vecs[9]  = '{300, 5, 2, 1, 12};
      vecs[10] = '{300, 5, 3, 1, 0};
      vecs[11] = '{600, 5, 3, 0, 0};
      vecs[12] = '{544, 0, 0, 1, 12};
      vecs[13] = '{545, 100, 2, 0, 0};
      vecs[14] = '{128, 50, 0, 1, 21};
      vecs[15] = '{100, 63, 0, 1, 21};

      rst_n = 1'b0; colPos = '0; rowPos = '0; frame_start = 1'b0; mode = '0; pause = 1'b0;
      model_reset();
      #1;
      check("reset_en", int'(display_enable), 0);
      check("reset_color", int'(color), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         colPos = 10'(vecs[i].col); rowPos = 10'(vecs[i].row); mode = 2'(vecs[i].md);
         @(posedge clk);
         #1;
         check("vec_en", int'(display_enable), vecs[i].en);
         check("vec_color", int'(color), vecs[i].color);
      end

      // Eight unpaused frames, pixel sampled on each pulse must still see old offsets.
      for (int i = 0; i < 8; i++) step(96 + 7 * i, 64 + 32 * (i % 4), 1, 1'b1, 1'b0);
      exp_off = '{32, 1984, 96, 1920};
      for (int k = 0; k < 4; k++) check("off_8frames", int'(dut.offs[k]), exp_off[k]);

      // Paused pulses leave everything frozen.
      for (int i = 0; i < 5; i++) step(150 + 11 * i, 70 + 32 * i, 1, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) check("off_paused", int'(dut.offs[k]), exp_off[k]);

      // frame_start held for three cycles counts three times.
      for (int i = 0; i < 3; i++) step(200, 100, 1, 1'b1, 1'b0);
      check_offs();

      // Wrap: from reset, one pulse takes lane 1 from 0 to 2040; 512 pulses take lane 0 back to 0.
      @(negedge clk); rst_n = 1'b0; model_reset();
      @(negedge clk); rst_n = 1'b1;
      step(300, 30, 2, 1'b1, 1'b0);
      check("off1_wrap", int'(dut.offs[1]), 2040);
      for (int i = 1; i < 511; i++) step(300, 30, 0, 1'b1, 1'b0);
      check("off0_2044", int'(dut.offs[0]), 2044);
      step(300, 70, 1, 1'b1, 1'b0);
      check("off0_wrap0", int'(dut.offs[0]), 0);
      check_offs();

      // Random traffic against the model.
      for (int i = 0; i < 600; i++)
         step(int'($urandom_range(0, 700)), int'($urandom_range(0, 260)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
      check_offs();

      // Asynchronous reset between edges while showing a colored pixel.
      step(300, 100, 2, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_en", int'(display_enable), 0);
      check("async_rst_color", int'(color), 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold_en", int'(display_enable), 0);
      check_offs();
      #2;
      rst_n = 1'b1;
      step(96, 31, 0, 1'b0, 1'b0);
      step(96, 64, 1, 1'b0, 1'b0);
      check_offs();

      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end

endmodule

// File: doc/grid_pattern_gen.md
GRID_PATTERN_GEN -- requirements
Module: grid_pattern_gen

Interface
REQ-001 Parameter COL_BITS, default 10: width of colPos/rowPos.
REQ-002 Parameter FIELD_LEFT, default 96: first visible play-field column, inclusive.
REQ-003 Parameter FIELD_RIGHT, default 544: last visible play-field column, inclusive.
REQ-004 Parameter TILE_LOG2, default 5: tile edge is 2^TILE_LOG2 pixels.
REQ-005 Parameter HEADER_ROWS, default 16: rows 0..HEADER_ROWS-1 form the header bar.
REQ-006 Parameter NUM_LANES, default 4: number of scrolling lanes, 1..8.
REQ-007 Parameter LANE_ROW0, default 64: first row of lane 0; lane k covers rows LANE_ROW0+k*2^TILE_LOG2 .. +2^TILE_LOG2-1.
REQ-008 Parameter SCROLL_STEP, default 4: base per-frame scroll increment.
REQ-009 clk  in  1  pixel clock; all state on rising edge.
REQ-010 rst_n  in  1  reset, asynchronous, active-low.
REQ-011 colPos  in  COL_BITS  current pixel column.
REQ-012 rowPos  in  COL_BITS  current pixel row.
REQ-013 frame_start  in  1  one-cycle pulse once per frame, during vertical blanking.
REQ-014 mode  in  2  0 grid, 1 lanes, 2 solid, 3 blank.
REQ-015 pause  in  1  freezes all scroll offsets while high.
REQ-016 display_enable  out  1  registered; high when the pixel is inside the play field.
REQ-017 color  out  6  registered RRGGBB pixel color.

Function
REQ-018 Outputs SHALL be registered, latency exactly 1 clk from colPos/rowPos/mode to display_enable/color.
REQ-019 In-field (FIELD_LEFT <= colPos <= FIELD_RIGHT): display_enable=1; otherwise display_enable=0, color=6'b000000, regardless of mode.
REQ-020 Header: in-field and rowPos < HEADER_ROWS SHALL give color=COLOR_HEADER (6'b001100) in modes 0-2; header has priority over all patterns.
REQ-021 Mode 0: lum = (colPos mod 2^TILE_LOG2 == 0) OR ((rowPos+1) mod 2^TILE_LOG2 == 0); color = COLOR_GRID (6'b010101) if lum, else 0.
REQ-022 Mode 1: row inside lane k -> stripe = bit TILE_LOG2 of (colPos + off_k) in COL_BITS+1 bits; color = COLOR_LANE_A (6'b000011) if 0, COLOR_LANE_B (6'b111111) if 1; rows outside every lane -> COLOR_BG (6'b000100).
REQ-023 Mode 2: color=COLOR_BG for all in-field non-header pixels; mode 3: color=0 but display_enable still follows REQ-019.
REQ-024 Each lane k SHALL hold offset off_k, width COL_BITS+1, modulo 2^(COL_BITS+1) wrap.
REQ-025 On a clk edge with frame_start=1 and pause=0: even k off_k += SCROLL_STEP*(k+1); odd k off_k -= SCROLL_STEP*(k+1); otherwise hold.
REQ-026 Offsets SHALL update in every mode, so returning to mode 1 shows continued motion.
REQ-027 Pixel sampled in the same cycle as frame_start SHALL use the pre-update offset.
REQ-028 mode change SHALL affect the output of the very next registered pixel; no stale pipeline content beyond 1 cycle.
REQ-029 frame_start held high for N cycles SHALL advance offsets N times (no edge detection).

Reset
REQ-030 rst_n low SHALL immediately force display_enable=0, color=0, all off_k=0, independent of clk.
REQ-031 Reset deassertion mid-frame: first edge after release computes from current inputs; no frame re-alignment required.

Structure
REQ-032 Package grid_pattern_pkg SHALL hold the color constants (COLOR_HEADER, COLOR_GRID, COLOR_LANE_A, COLOR_LANE_B, COLOR_BG) and a mode enum type (MODE_GRID, MODE_LANES, MODE_SOLID, MODE_BLANK).
REQ-033 Sub-module lane_scroller (parameters COL_BITS, STEP, DIR) SHALL implement one offset counter; grid_pattern_gen instantiates NUM_LANES copies via generate.

Verification
REQ-034 Reset, mode 0, col=96 row=31 -> next cycle enable=1, color=6'b010101; col=97 row=40 -> color=0; col=95 -> enable=0 color=0.
REQ-035 Mode 1, row=10, col=200 -> color=6'b001100 (header wins); row=64, col=96, offsets 0 -> color=6'b111111 (bit5 of 96=1).
REQ-036 Mode 1, 8 frame_start pulses, pause=0 -> off_0=32, off_1=2048-64=1984, off_2=96, off_3=2048-128=1920.
REQ-037 pause=1 across 5 frame_start pulses -> offsets unchanged; frame_start coincident with pixel uses old offset.
REQ-038 off_0 starting at 2044, one pulse -> wraps to 0; off_1 at 0, one pulse -> 2040.
REQ-039 Assert rst_n low mid-line with color nonzero -> color=0, enable=0 without a clk edge; offsets read 0 after release.
